// File: rtl/gate_pkg.sv
// Shared constants for the round-robin gate arbiter: op codes and widths.
package gate_pkg;

  localparam int OPW  = 3;
  localparam int CNTW = 8;

  localparam logic [OPW-1:0] OP_AND  = 3'd0;
  localparam logic [OPW-1:0] OP_OR   = 3'd1;
  localparam logic [OPW-1:0] OP_NAND = 3'd2;
  localparam logic [OPW-1:0] OP_NOR  = 3'd3;
  localparam logic [OPW-1:0] OP_XOR  = 3'd4;
  localparam logic [OPW-1:0] OP_XNOR = 3'd5;
  localparam logic [OPW-1:0] OP_NOTA = 3'd6;
  localparam logic [OPW-1:0] OP_BUFA = 3'd7;

endpackage

// File: rtl/gate_alu.sv
// Shared 2-input logic-gate evaluation unit; purely combinational.
module gate_alu
  import gate_pkg::*;
(
  input  logic [OPW-1:0] op,
  input  logic           a,
  input  logic           b,
  output logic           y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/gate_rr_arbiter.sv
// Round-robin arbiter sharing one gate_alu among N requesters, single-entry
// valid/ready response slot. Optional per-requester grant counters: GATE_ARB_STATS_EN.
module gate_rr_arbiter
  import gate_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  input  logic [OPW*N-1:0] op_in,
  output logic [N-1:0]     gnt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_y,
  output logic [IDW-1:0]   resp_id
`ifdef GATE_ARB_STATS_EN
  ,
  output logic [N*CNTW-1:0] grant_cnt
`endif
);

  logic [IDW-1:0] ptr_reg, ptr_next;
  logic           resp_valid_reg, resp_y_reg;
  logic [IDW-1:0] resp_id_reg;
  logic [OPW-1:0] op_arr [N];
  logic [OPW-1:0] op_sel;
  logic           a_sel, b_sel, y_alu;
  logic           free, any_gnt;
  logic [N-1:0]   gnt_int;
  logic [IDW-1:0] win_idx;

  for (genvar gi = 0; gi < N; gi++) begin : g_op_split
    assign op_arr[gi] = op_in[OPW*gi +: OPW];
  end

  assign free = !resp_valid_reg || resp_ready;

  // Search upward from ptr: lowest set bit at or above ptr wins, otherwise
  // wrap to the lowest set bit overall.
  always_comb begin
    int first_hi;
    int first_lo;
    int sel;
    first_hi = -1;
    first_lo = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i >= int'(ptr_reg)) first_hi = i;
        first_lo = i;
      end
    end
    sel      = (first_hi >= 0) ? first_hi : first_lo;
    any_gnt  = free && !rst && (sel >= 0);
    gnt_int  = '0;
    win_idx  = '0;
    op_sel   = '0;
    a_sel    = 1'b0;
    b_sel    = 1'b0;
    ptr_next = ptr_reg;
    for (int i = 0; i < N; i++) begin
      if (i == sel) begin
        gnt_int[i] = any_gnt;
        op_sel     = op_arr[i];
        a_sel      = a_in[i];
        b_sel      = b_in[i];
      end
    end
    if (any_gnt) begin
      win_idx  = IDW'(sel);
      ptr_next = (sel == N - 1) ? '0 : IDW'(sel + 1);
    end
  end

  gate_alu u_alu (
    .op (op_sel),
    .a  (a_sel),
    .b  (b_sel),
    .y  (y_alu)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_reg <= 1'b0;
      resp_y_reg     <= 1'b0;
      resp_id_reg    <= '0;
      ptr_reg        <= '0;
    end else begin
      ptr_reg <= ptr_next;
      if (any_gnt) begin
        resp_valid_reg <= 1'b1;
        resp_y_reg     <= y_alu;
        resp_id_reg    <= win_idx;
      end else if (resp_ready) begin
        resp_valid_reg <= 1'b0;
      end
    end
  end

  assign gnt        = gnt_int;
  assign resp_valid = resp_valid_reg;
  assign resp_y     = resp_y_reg;
  assign resp_id    = resp_id_reg;

`ifdef GATE_ARB_STATS_EN
  for (genvar gi = 0; gi < N; gi++) begin : g_stats
    logic [CNTW-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (gnt_int[gi] && (cnt_reg != {CNTW{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
    assign grant_cnt[gi*CNTW +: CNTW] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_gate_rr_arbiter.sv
// Directed bench for gate_rr_arbiter: truth table vectors plus hand-written
// reset, fairness, pointer-wrap, backpressure and (optional) stats sequences.
module tb_gate_rr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, a_in, b_in, gnt;
  logic [3*N-1:0] op_in;
  logic           resp_valid, resp_ready, resp_y;
  logic [IDW-1:0] resp_id;
`ifdef GATE_ARB_STATS_EN
  logic [N*8-1:0] grant_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  gate_rr_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .op_in      (op_in),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .resp_id    (resp_id)
`ifdef GATE_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic       a;
    logic       b;
    logic       y;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // op, a, b, expected y (requester 2)
    vecs[0]  = '{3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'd0, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{3'd4, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{3'd4, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{3'd4, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{3'd1, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{3'd1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd2, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{3'd3, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{3'd5, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3'd5, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{3'd6, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{3'd7, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; req = 4'b1111; a_in = '0; b_in = '0; op_in = '0; resp_ready = 1'b1;
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(resp_valid), 32'h0);
    chk("rst_id", 32'(resp_id), 32'h0);
    chk("rst_y", 32'(resp_y), 32'h0);

    // Fairness straight out of reset: 0,1,2,3,0,...
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("fair_gnt%0d", i), 32'(gnt), 32'(1 << (i % 4)));
      tick();
      chk($sformatf("fair_id%0d", i), 32'(resp_id), 32'(i % 4));
      chk($sformatf("fair_valid%0d", i), 32'(resp_valid), 32'h1);
    end

    // Truth table through requester 2, other lanes carry inverted decoys
    for (int i = 0; i < 16; i++) begin
      req   = 4'b0100;
      op_in = {~vecs[i].op, vecs[i].op, ~vecs[i].op, ~vecs[i].op};
      a_in  = {~vecs[i].a, vecs[i].a, ~vecs[i].a, ~vecs[i].a};
      b_in  = {~vecs[i].b, vecs[i].b, ~vecs[i].b, ~vecs[i].b};
      #1;
      chk($sformatf("tt_gnt%0d", i), 32'(gnt), 32'h4);
      tick();
      chk($sformatf("tt_y%0d_op%0d", i, vecs[i].op), 32'(resp_y), 32'(vecs[i].y));
      chk($sformatf("tt_id%0d", i), 32'(resp_id), 32'h2);
    end

    // Drain without refill: slot empties, data held
    req = 4'b0000;
    #1;
    chk("drain_gnt", 32'(gnt), 32'h0);
    tick();
    chk("drain_valid", 32'(resp_valid), 32'h0);
    chk("drain_id", 32'(resp_id), 32'h2);
    chk("drain_y", 32'(resp_y), 32'h1);

    // Pointer at 3 after granting 2: req 0101 wraps to 0, then 2
    op_in = 12'b001_001_001_001; a_in = 4'b1001; b_in = 4'b0000;
    req = 4'b0101;
    #1;
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    tick();
    chk("wrap_id0", 32'(resp_id), 32'h0);
    chk("wrap_y0", 32'(resp_y), 32'h1);
    chk("wrap_gnt1", 32'(gnt), 32'h4);
    tick();
    chk("wrap_id1", 32'(resp_id), 32'h2);
    chk("wrap_y1", 32'(resp_y), 32'h0);

    // Backpressure: slot full, no grants, data stable
    resp_ready = 1'b0; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_gnt%0d", i), 32'(gnt), 32'h0);
      tick();
      chk($sformatf("bp_valid%0d", i), 32'(resp_valid), 32'h1);
      chk($sformatf("bp_id%0d", i), 32'(resp_id), 32'h2);
      chk($sformatf("bp_y%0d", i), 32'(resp_y), 32'h0);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_gnt", 32'(gnt), 32'h8);
    tick();
    chk("bp_refill_valid", 32'(resp_valid), 32'h1);
    chk("bp_refill_id", 32'(resp_id), 32'h3);
    chk("bp_refill_y", 32'(resp_y), 32'h1);

    // Reset mid-operation discards the slot and restarts the pointer
    resp_ready = 1'b0; rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    tick();
    chk("mid_rst_valid", 32'(resp_valid), 32'h0);
    rst = 1'b0; req = 4'b1100;
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h4);
    tick();
    chk("post_rst_id", 32'(resp_id), 32'h2);
    chk("post_rst_valid", 32'(resp_valid), 32'h1);

`ifdef GATE_ARB_STATS_EN
    rst = 1'b1; resp_ready = 1'b1; req = 4'b0010;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    chk("cnt1_sat", 32'(grant_cnt[15:8]), 32'd255);
    chk("cnt0", 32'(grant_cnt[7:0]), 32'd0);
    chk("cnt2", 32'(grant_cnt[23:16]), 32'd0);
    chk("cnt3", 32'(grant_cnt[31:24]), 32'd0);
`endif

    req = '0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_rr_arbiter.md
Name: gate_rr_arbiter

Overview:
- Shares one 2-input logic-gate evaluation unit among N requesters using round-robin arbitration.
- Each requester presents operands a/b and an op code. The winner's result is registered into a single-entry response slot, tagged with the requester index, and held under a valid/ready handshake.
- Sits between multiple gate-test clients and the shared gate datapath.

Parameters:
- N, 4, number of requesters (1..16).
- IDW, 2, width of resp_id; must be at least 1 and at least clog2(N).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req  in  N  per-requester request; held high until the matching gnt is seen
- a_in  in  N  operand a, bit i belongs to requester i
- b_in  in  N  operand b, bit i belongs to requester i
- op_in  in  3*N  op code, bits [3i+2:3i] belong to requester i
- gnt  out  N  one-hot grant, combinational, at most one bit set
- resp_valid  out  1  response slot occupied
- resp_ready  in  1  consumer accepts the response this cycle
- resp_y  out  1  gate result
- resp_id  out  IDW  index of the requester that produced resp_y

Behaviour:
- Op encoding:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a (b ignored), 7 BUF a.
  - All 8 codes are defined; there is no illegal op.
- Reset (synchronous, rst=1 at clk edge):
  - resp_valid=0, resp_y=0, resp_id=0, rotation pointer ptr=0.
  - gnt is forced to 0 while rst=1.
- Slot-free condition: free = !resp_valid || resp_ready.
- Grant:
  - When free=1 and |req=1, gnt selects the first set req bit found by searching upward from ptr, wrapping at N-1 to 0.
  - When free=0 or req=0, gnt=0.
- Pointer update: on a grant to index i, ptr <= (i==N-1) ? 0 : i+1. It does not wrap at 2^IDW. With no grant, ptr holds.
- Result capture, latency 1 cycle:
  - On a grant edge: resp_y <= f(op,a,b) for the granted requester, resp_id <= i, resp_valid <= 1.
- Drain without refill: resp_valid=1, resp_ready=1, no req → resp_valid <= 0; resp_y and resp_id hold their stale values.
- Simultaneous drain and grant: the slot is refilled in the same edge, resp_valid stays 1, with zero bubble.
- Backpressure: resp_valid=1, resp_ready=0 → resp_y and resp_id are stable, gnt=0, and requests wait.
- Requester contract: a requester drops or changes req/operands only after the cycle in which its gnt bit is high. Requests are not dropped by the arbiter.
- Fairness: with all N requesting continuously and resp_ready=1, grants follow the sequence ptr, ptr+1, … and each requester is served exactly once per N grants.
- N=1: ptr is constant 0, and gnt[0]=req[0]&free.
- Reset mid-operation: a pending response is discarded. The first grant after reset goes to the lowest-index active requester.
- States (implicit in resp_valid):
  - EMPTY → FULL on a grant.
  - FULL → EMPTY on ready with no grant.
  - FULL → FULL on ready with a grant, or on !ready.

Optional Feature:
- Macro: GATE_ARB_STATS_EN.
- When defined:
  - Adds output port grant_cnt (N*8 bits), one 8-bit saturating counter per requester.
  - A counter increments on each grant to that requester and saturates at 255.
  - All counters clear on rst.
- When undefined: the port and the counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package gate_pkg:
  - op code localparams (OP_AND..OP_BUF).
  - OPW=3.
  - Shared width constant for the per-requester counter (8).
- Sub-module gate_alu: purely combinational; inputs op, a, b; output y. It is the shared datapath and is instantiated once, fed by the granted requester's fields through a mux.

Test Plan:
- Reset: assert rst with req=4'b1111 → gnt=0 and resp_valid=0. After rst deasserts, first gnt=4'b0001 and resp_id=0 the next cycle.
- Truth table: requester 2 alone, op=AND (0) with a/b = 00, 01, 10, 11, resp_ready=1 → resp_y=0,0,0,1 with resp_id=2, each 1 cycle after its grant. Repeat for XOR (4) → 0,1,1,0.
- Fairness: req=4'b1111 held, resp_ready=1 for 8 cycles → gnt = 0001, 0010, 0100, 1000, 0001, … ; resp_id = 0,1,2,3,0,…
- Backpressure: resp_ready=0 after the first grant → gnt=0 and resp_y/resp_id stable for 5 cycles. Raising resp_ready gives a grant in that same cycle and resp_valid stays 1.
- Pointer skip and wrap: ptr=3 (after granting 2), req=4'b0101 → gnt=0001, then 0100.
- Stats (GATE_ARB_STATS_EN): 300 grants to requester 1 → grant_cnt[15:8]=255 and the other counters are 0.
